// File: rtl/q_accel_arbiter.sv
// q_accel_arbiter: shares one Q = ((a-b)*(1+3c)-4d)/2 accelerator among NUM_REQ requesters.
// Round-robin admits at most one operand set per cycle; an in-order tag FIFO steers each
// result back to its requester one cycle after acc_valid_out (registered).
// Ports: req_valid/req_ready + req_a..d (packed slices) from requesters; rsp_valid (one-hot)
// + shared rsp_q back to them; acc_valid_in/acc_a..d to the accelerator, acc_valid_out/
// acc_q_out from it; busy = tags in flight; err_underflow = sticky result-without-tag flag.
module q_accel_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TAG_DEPTH  = 8,
  parameter int MAX_OUTST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [2*DATA_WIDTH-1:0]       rsp_q,
  output logic                          acc_valid_in,
  output logic [DATA_WIDTH-1:0]         acc_a,
  output logic [DATA_WIDTH-1:0]         acc_b,
  output logic [DATA_WIDTH-1:0]         acc_c,
  output logic [DATA_WIDTH-1:0]         acc_d,
  input  logic                          acc_valid_out,
  input  logic [2*DATA_WIDTH-1:0]       acc_q_out,
  output logic                          busy,
  output logic                          err_underflow
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [TW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]           outst_q [NUM_REQ];
  logic [OW-1:0]           outst_d [NUM_REQ];
  logic [TW-1:0]           tag_mem_q [TAG_DEPTH];
  logic [TW-1:0]           tag_mem_d [TAG_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    acc_valid_in_q, acc_valid_in_d;
  logic [DATA_WIDTH-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [DATA_WIDTH-1:0]   acc_c_q, acc_c_d, acc_d_q, acc_d_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] rsp_q_q, rsp_q_d;
  logic                    err_q, err_d;

  logic               tag_full, tag_empty, issue, pop;
  logic [NUM_REQ-1:0] eligible, gnt_oh, pop_oh;
  logic [TW-1:0]      gnt_idx, cand, pop_tag;

  // Full is judged on the registered count, so a pop in the same cycle never frees a slot early.
  assign tag_full  = (count_q == CW'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);
  assign pop       = acc_valid_out && !tag_empty;
  assign pop_tag   = tag_mem_q[rd_ptr_q];
  assign pop_oh    = pop ? (NUM_REQ'(1) << pop_tag) : '0;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = !reset && req_valid[i] && (outst_q[i] < OW'(MAX_OUTST)) && !tag_full;
    end
  end

  // Round-robin: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = '0;
    issue   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = TW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!issue && eligible[cand]) begin
        issue         = 1'b1;
        gnt_idx       = cand;
        gnt_oh[cand]  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    outst_d        = outst_q;
    tag_mem_d      = tag_mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    acc_valid_in_d = issue;
    acc_a_d        = acc_a_q;
    acc_b_d        = acc_b_q;
    acc_c_d        = acc_c_q;
    acc_d_d        = acc_d_q;
    rsp_valid_d    = pop_oh;
    rsp_q_d        = rsp_q_q;
    err_d          = err_q || (acc_valid_out && tag_empty);

    if (issue) begin
      rr_ptr_d  = (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + TW'(1);
      acc_a_d   = req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      acc_b_d   = req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      acc_c_d   = req_c[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      acc_d_d   = req_d[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      tag_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d  = (wr_ptr_q == PW'(TAG_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rsp_q_d  = acc_q_out;
      rd_ptr_d = (rd_ptr_q == PW'(TAG_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    if (issue && !pop)      count_d = count_q + CW'(1);
    else if (pop && !issue) count_d = count_q - CW'(1);

    // Issue and return for the same requester in one cycle cancel out.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i] && !pop_oh[i])      outst_d[i] = outst_q[i] + OW'(1);
      else if (pop_oh[i] && !gnt_oh[i]) outst_d[i] = outst_q[i] - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      acc_valid_in_q <= 1'b0;
      acc_a_q        <= '0;
      acc_b_q        <= '0;
      acc_c_q        <= '0;
      acc_d_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_q_q        <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      acc_valid_in_q <= acc_valid_in_d;
      acc_a_q        <= acc_a_d;
      acc_b_q        <= acc_b_d;
      acc_c_q        <= acc_c_d;
      acc_d_q        <= acc_d_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_q_q        <= rsp_q_d;
      err_q          <= err_d;
      outst_q        <= outst_d;
    end
  end

  // Tag storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  assign req_ready     = gnt_oh;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_q         = rsp_q_q;
  assign acc_valid_in  = acc_valid_in_q;
  assign acc_a         = acc_a_q;
  assign acc_b         = acc_b_q;
  assign acc_c         = acc_c_q;
  assign acc_d         = acc_d_q;
  assign busy          = !tag_empty;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_q_accel_arbiter.sv
module tb_q_accel_arbiter;

  localparam int DW      = 32;
  localparam int NR      = 4;
  localparam int ACC_LAT = 2;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a, req_b, req_c, req_d;
  logic [NR-1:0]     rsp_valid;
  logic [2*DW-1:0]   rsp_q;
  logic              acc_valid_in;
  logic [DW-1:0]     acc_a, acc_b, acc_c, acc_d;
  logic              acc_valid_out;
  logic [2*DW-1:0]   acc_q_out;
  logic              busy;
  logic              err_underflow;

  q_accel_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_DEPTH(4), .MAX_OUTST(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q),
    .acc_valid_in(acc_valid_in),
    .acc_a(acc_a), .acc_b(acc_b), .acc_c(acc_c), .acc_d(acc_d),
    .acc_valid_out(acc_valid_out), .acc_q_out(acc_q_out),
    .busy(busy), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester operand sets and hand-computed results.
  int          op_a [NR] = '{10, -7, 0, 100};
  int          op_b [NR] = '{4, 5, 1, -20};
  int          op_c [NR] = '{2, -1, 0, 5};
  int          op_d [NR] = '{3, -2, 0, 7};
  logic [63:0] exp_q [NR];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accelerator model: fixed latency, optional stall, shares reset.
  logic          stall, spur;
  logic [63:0]   aq_dat [$];
  int            aq_due [$];
  logic [127:0]  acc_log [$];

  function automatic logic [63:0] q_model(input logic [31:0] a, b, c, d);
    longint t;
    t = (longint'(signed'(a)) - longint'(signed'(b))) * (1 + 3 * longint'(signed'(c)))
        - 4 * longint'(signed'(d));
    return 64'(t >>> 1);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      aq_dat.delete();
      aq_due.delete();
      acc_valid_out = 1'b0;
      acc_q_out     = '0;
    end else begin
      if (acc_valid_in) begin
        aq_dat.push_back(q_model(acc_a, acc_b, acc_c, acc_d));
        aq_due.push_back(cyc + ACC_LAT);
        acc_log.push_back({acc_a, acc_b, acc_c, acc_d});
      end
      acc_valid_out = 1'b0;
      if (spur) begin
        acc_valid_out = 1'b1;
        acc_q_out     = 64'h1234;
      end else if (!stall && aq_due.size() > 0 && aq_due[0] <= cyc) begin
        acc_valid_out = 1'b1;
        acc_q_out     = aq_dat.pop_front();
        void'(aq_due.pop_front());
      end
    end
  end

  // Monitor: grants and responses with the cycle they were seen in.
  int          gnt_idx_log [$];
  int          gnt_cyc_log [$];
  logic [3:0]  rsp_vld_log [$];
  logic [63:0] rsp_dat_log [$];
  int          rsp_cyc_log [$];
  logic        rsp_busy_log [$];

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          gnt_idx_log.push_back(i);
          gnt_cyc_log.push_back(cyc);
        end
      end
      if (rsp_valid != '0) begin
        rsp_vld_log.push_back(rsp_valid);
        rsp_dat_log.push_back(rsp_q);
        rsp_cyc_log.push_back(cyc);
        rsp_busy_log.push_back(busy);
      end
    end
  end

  task automatic clear_logs();
    gnt_idx_log.delete(); gnt_cyc_log.delete();
    rsp_vld_log.delete(); rsp_dat_log.delete();
    rsp_cyc_log.delete(); rsp_busy_log.delete();
    acc_log.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_idle"}, 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_single(input int idx);
    @(posedge clk); #1;
    clear_logs();
    req_valid = 4'b0001 << idx;
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("single");
  endtask

  task automatic stream(input logic [3:0] vmask, input int ncyc);
    @(posedge clk); #1;
    clear_logs();
    req_valid = vmask;
    repeat (ncyc) @(posedge clk);
    #1 req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t3_off [6] = '{0, 1, 4, 5, 8, 9};
    int t4_off [9] = '{0, 1, 2, 3, 9, 10, 11, 12, 13};
    int t4_idx [9] = '{2, 0, 1, 2, 0, 1, 2, 0, 1};
    int idx;

    exp_q = '{64'd15, 64'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'd946};
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = op_a[i];
      req_b[i*DW +: DW] = op_b[i];
      req_c[i*DW +: DW] = op_c[i];
      req_d[i*DW +: DW] = op_d[i];
    end
    reset = 1'b1; req_valid = '0; stall = 1'b0; spur = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 64'(req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_q", rsp_q, 64'd0);
    check_val("rst_acc_valid_in", 64'(acc_valid_in), 64'd0);
    check_val("rst_acc_a", 64'(acc_a), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_err", 64'(err_underflow), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: single op from requester 0
    run_single(0);
    check_val("t1_ngnt", 64'(gnt_idx_log.size()), 64'd1);
    check_val("t1_gnt_idx", 64'(gnt_idx_log[0]), 64'd0);
    check_val("t1_acc_a", 64'(acc_log[0][127:96]), 64'd10);
    check_val("t1_acc_d", 64'(acc_log[0][31:0]), 64'd3);
    check_val("t1_nrsp", 64'(rsp_vld_log.size()), 64'd1);
    check_val("t1_rsp_vld", 64'(rsp_vld_log[0]), 64'b0001);
    check_val("t1_rsp_q", rsp_dat_log[0], 64'd15);
    check_val("t1_latency", 64'(rsp_cyc_log[0] - gnt_cyc_log[0]), 64'(ACC_LAT + 2));
    check_val("t1_busy_at_rsp", 64'(rsp_busy_log[0]), 64'd0);

    // 2: all four streaming; rr_ptr is 1 after test 1
    stream(4'b1111, 12);
    wait_idle("t2");
    check_val("t2_ngnt", 64'(gnt_idx_log.size()), 64'd12);
    check_val("t2_nrsp", 64'(rsp_vld_log.size()), 64'd12);
    for (int n = 0; n < 12; n++) begin
      idx = (1 + n) % NR;
      check_val($sformatf("t2_gnt_idx%0d", n), 64'(gnt_idx_log[n]), 64'(idx));
      check_val($sformatf("t2_gnt_cyc%0d", n), 64'(gnt_cyc_log[n] - gnt_cyc_log[0]), 64'(n));
      check_val($sformatf("t2_rsp_vld%0d", n), 64'(rsp_vld_log[n]), 64'(4'b0001 << idx));
      check_val($sformatf("t2_rsp_q%0d", n), rsp_dat_log[n], exp_q[idx]);
    end

    // 3: req1 alone hits MAX_OUTST=2; ready gaps of two cycles
    stream(4'b0010, 10);
    wait_idle("t3");
    check_val("t3_ngnt", 64'(gnt_idx_log.size()), 64'd6);
    check_val("t3_nrsp", 64'(rsp_vld_log.size()), 64'd6);
    for (int n = 0; n < 6; n++) begin
      check_val($sformatf("t3_gnt_off%0d", n), 64'(gnt_cyc_log[n] - gnt_cyc_log[0]), 64'(t3_off[n]));
      check_val($sformatf("t3_rsp_vld%0d", n), 64'(rsp_vld_log[n]), 64'b0010);
    end

    // 4: stalled accelerator fills the 4-deep tag FIFO, then release while streaming
    @(posedge clk); #1;
    clear_logs();
    stall = 1'b1;
    req_valid = 4'b0111;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check_val("t4_full_ready", 64'(req_ready), 64'd0);
    check_val("t4_full_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 stall = 1'b0;
    repeat (6) @(posedge clk);
    #1 req_valid = '0;
    wait_idle("t4");
    check_val("t4_ngnt", 64'(gnt_idx_log.size()), 64'd9);
    check_val("t4_nrsp", 64'(rsp_vld_log.size()), 64'd9);
    for (int n = 0; n < 9; n++) begin
      check_val($sformatf("t4_gnt_off%0d", n), 64'(gnt_cyc_log[n] - gnt_cyc_log[0]), 64'(t4_off[n]));
      check_val($sformatf("t4_gnt_idx%0d", n), 64'(gnt_idx_log[n]), 64'(t4_idx[n]));
      check_val($sformatf("t4_rsp_q%0d", n), rsp_dat_log[n], exp_q[t4_idx[n]]);
    end

    // 5: negative operands and arithmetic shift
    run_single(1);
    check_val("t5_neg_vld", 64'(rsp_vld_log[0]), 64'b0010);
    check_val("t5_neg_q", rsp_dat_log[0], 64'd16);
    run_single(2);
    check_val("t5_m1_vld", 64'(rsp_vld_log[0]), 64'b0100);
    check_val("t5_m1_q", rsp_dat_log[0], 64'hFFFF_FFFF_FFFF_FFFF);

    // 6: reset with three ops in flight, then a spurious accelerator result
    stream(4'b0111, 3);
    reset = 1'b1;
    @(negedge clk);
    check_val("t6_inflight_gnt", 64'(gnt_idx_log.size()), 64'd3);
    check_val("t6_inflight_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_val("t6_ready", 64'(req_ready), 64'd0);
    check_val("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("t6_rsp_q", rsp_q, 64'd0);
    check_val("t6_acc_valid_in", 64'(acc_valid_in), 64'd0);
    check_val("t6_acc_a", 64'(acc_a), 64'd0);
    check_val("t6_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    check_val("t6_no_rsp", 64'(rsp_vld_log.size()), 64'd0);
    check_val("t6_err_clear", 64'(err_underflow), 64'd0);
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    check_val("t6_err_set", 64'(err_underflow), 64'd1);
    check_val("t6_spur_rsp", 64'(rsp_valid), 64'd0);
    check_val("t6_spur_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check_val("t6_spur_nrsp", 64'(rsp_vld_log.size()), 64'd0);
    run_single(3);
    check_val("t6_post_vld", 64'(rsp_vld_log[0]), 64'b1000);
    check_val("t6_post_q", rsp_dat_log[0], 64'd946);
    check_val("t6_err_sticky", 64'(err_underflow), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
